// File: rtl/missile_controller.sv
// Missile sprite controller: launches from the owning tank, flies in 8.4 fixed point, and ends on collision, off-screen or lifetime.
// Define MISSILE_EXPLODE_EN to add a blinking explosion phase after a collision.
module missile_controller #(
  parameter int SPEED          = 2,
  parameter int LIFETIME       = 60,
  parameter int EXPLODE_FRAMES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [8:0] hpos,
  input  logic [8:0] vpos,
  input  logic       vsync,
  input  logic       fire,
  input  logic [7:0] tank_x,
  input  logic [7:0] tank_y,
  input  logic [3:0] tank_rot,
  input  logic       playfield,
  output logic       gfx,
  output logic       active,
  output logic       hit
);

`ifdef MISSILE_EXPLODE_EN
  typedef enum logic [1:0] {IDLE, FLY, EXPLODE} state_t;
`else
  typedef enum logic [1:0] {IDLE, FLY} state_t;
`endif

  state_t            state, state_d;
  logic [11:0]       x, y, x_d, y_d;
  logic [3:0]        rot, rot_d;
  logic [7:0]        life, life_d, life_inc, lx, ly;
  logic              vsync_d, fire_d, fire_req, coll, hit_d, gfx_d;
  logic              tick, launch, off_screen, draw_fly;
  logic signed [3:0] sin_x, sin_y;
  logic [12:0]       dx, dy, x_sum, y_sum;
  logic [8:0]        xi, yi;

  // Coarse 16-step sine, amplitude 7.
  function automatic logic signed [3:0] sin4(input logic [3:0] r);
    logic [2:0] base;
    case (r[1:0])
      2'd0:    base = 3'd0;
      2'd1:    base = 3'd3;
      2'd2:    base = 3'd5;
      default: base = 3'd6;
    endcase
    case (r[3:2])
      2'd0:    sin4 = signed'({1'b0, base});
      2'd1:    sin4 = 4'sd7 - signed'({1'b0, base});
      2'd2:    sin4 = -signed'({1'b0, base});
      default: sin4 = signed'({1'b0, base}) - 4'sd7;
    endcase
  endfunction

  assign tick       = vsync & ~vsync_d;
  assign launch     = tick && (state == IDLE) && fire_req;
  assign active     = (state != IDLE);
  assign sin_x      = sin4(rot);
  assign sin_y      = sin4(rot + 4'd4);
  assign dx         = 13'(SPEED * int'(sin_x));
  assign dy         = 13'(-(SPEED * int'(sin_y)));
  assign x_sum      = {1'b0, x} + dx;
  assign y_sum      = {1'b0, y} + dy;
  assign off_screen = x_sum[12] | y_sum[12] | (y_sum[11:4] >= 8'd240);
  assign life_inc   = life + 8'd1;
  assign lx         = tank_x + 8'd8;
  assign ly         = tank_y + 8'd8;

`ifdef MISSILE_EXPLODE_EN
  logic [7:0] expl_cnt, expl_d, expl_inc;
  logic [8:0] hd, vd;
  assign expl_inc = expl_cnt + 8'd1;
`else
  // Explosion length has no meaning without the explosion phase.
  logic unused_cfg;
  assign unused_cfg = (EXPLODE_FRAMES != 0);
`endif

  always_comb begin
    state_d = state;
    x_d     = x;
    y_d     = y;
    rot_d   = rot;
    life_d  = life;
    hit_d   = 1'b0;
`ifdef MISSILE_EXPLODE_EN
    expl_d  = expl_cnt;
`endif
    if (tick) begin
      case (state)
        IDLE: if (fire_req) begin
          state_d = FLY;
          x_d     = {lx, 4'b0};
          y_d     = {ly, 4'b0};
          rot_d   = tank_rot;
          life_d  = 8'd0;
        end
        FLY: begin
          // Collision wins over off-screen, which wins over lifetime.
          if (coll) begin
            hit_d   = 1'b1;
`ifdef MISSILE_EXPLODE_EN
            state_d = EXPLODE;
            expl_d  = 8'd0;
`else
            state_d = IDLE;
`endif
          end else if (off_screen) begin
            state_d = IDLE;
          end else if (life_inc == 8'(LIFETIME)) begin
            state_d = IDLE;
          end else begin
            x_d    = x_sum[11:0];
            y_d    = y_sum[11:0];
            life_d = life_inc;
          end
        end
`ifdef MISSILE_EXPLODE_EN
        EXPLODE: if (expl_inc == 8'(EXPLODE_FRAMES)) state_d = IDLE;
                 else expl_d = expl_inc;
`endif
        default: state_d = IDLE;
      endcase
    end
  end

  // Drawn from next-state values so gfx drops together with the state change.
  always_comb begin
    xi       = {1'b0, x_d[11:4]};
    yi       = {1'b0, y_d[11:4]};
    draw_fly = (hpos == xi || hpos == xi + 9'd1) && (vpos == yi || vpos == yi + 9'd1);
    gfx_d    = (state_d == FLY) && draw_fly;
`ifdef MISSILE_EXPLODE_EN
    hd = hpos - xi + 9'd1;
    vd = vpos - yi + 9'd1;
    if (state_d == EXPLODE && expl_d[1] && hd < 9'd4 && vd < 9'd4) gfx_d = 1'b1;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      x        <= '0;
      y        <= '0;
      rot      <= '0;
      life     <= '0;
      vsync_d  <= 1'b0;
      fire_d   <= 1'b0;
      fire_req <= 1'b0;
      coll     <= 1'b0;
      hit      <= 1'b0;
      gfx      <= 1'b0;
`ifdef MISSILE_EXPLODE_EN
      expl_cnt <= '0;
`endif
    end else begin
      state   <= state_d;
      x       <= x_d;
      y       <= y_d;
      rot     <= rot_d;
      life    <= life_d;
      vsync_d <= vsync;
      fire_d  <= fire;
      hit     <= hit_d;
      gfx     <= gfx_d;
`ifdef MISSILE_EXPLODE_EN
      expl_cnt <= expl_d;
`endif
      if (launch) fire_req <= 1'b0;
      else if (state == IDLE && fire && !fire_d) fire_req <= 1'b1;
      if (tick) coll <= 1'b0;
      else if (state == FLY && gfx && playfield) coll <= 1'b1;
    end
  end

endmodule

// File: tb/tb_missile_controller.sv
// Bench for missile_controller: fixed launch vectors, hand-built corner sequences, then random play against a frame-level model.
module tb_missile_controller;
  localparam int SPEED_T = 1;
  localparam int LIFE_T  = 60;
  localparam int EXPL_T  = 16;
`ifdef MISSILE_EXPLODE_EN
  localparam bit EXPL_EN = 1'b1;
`else
  localparam bit EXPL_EN = 1'b0;
`endif

  logic       clk = 1'b0, reset = 1'b0;
  logic [8:0] hpos = '0, vpos = '0;
  logic       vsync = 1'b0, fire = 1'b0, playfield = 1'b0;
  logic [7:0] tank_x = '0, tank_y = '0;
  logic [3:0] tank_rot = '0;
  logic       gfx, active, hit;
  int total = 0, bad = 0;

  missile_controller #(.SPEED(SPEED_T), .LIFETIME(LIFE_T), .EXPLODE_FRAMES(EXPL_T)) dut (
    .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos), .vsync(vsync), .fire(fire),
    .tank_x(tank_x), .tank_y(tank_y), .tank_rot(tank_rot), .playfield(playfield),
    .gfx(gfx), .active(active), .hit(hit));

  always #5 clk = ~clk;

  // Frame-level model: position in 1/16 pixel units, state 0 idle / 1 fly / 2 explode.
  int sin_t[16] = '{0, 3, 5, 6, 7, 4, 2, 1, 0, -3, -5, -6, -7, -4, -2, -1};
  int m_st = 0, mx = 0, my = 0, mlife = 0, mrot = 0, mexpl = 0;
  bit mreq = 0, mcoll = 0, mfire_prev = 0;

  typedef struct {int tx; int ty; int rot; int n; bit act; int xi; int yi;} vec_t;
  vec_t tbl[12];

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic void m_reset();
    m_st = 0; mreq = 0; mcoll = 0; mfire_prev = 0; mexpl = 0; mlife = 0;
  endfunction

  function automatic bit m_gfx(int h, int v);
    int xi = mx / 16, yi = my / 16;
    if (m_st == 1) return (h == xi || h == xi + 1) && (v == yi || v == yi + 1);
    if (m_st == 2) return ((mexpl / 2) % 2 == 1) && h >= xi - 1 && h <= xi + 2 && v >= yi - 1 && v <= yi + 2;
    return 1'b0;
  endfunction

  task automatic m_tick(output bit hexp);
    int nx, ny;
    hexp = 1'b0;
    case (m_st)
      0: if (mreq) begin
        m_st = 1; mx = ((int'(tank_x) + 8) % 256) * 16; my = ((int'(tank_y) + 8) % 256) * 16;
        mlife = 0; mrot = int'(tank_rot); mreq = 0;
      end
      1: begin
        nx = mx + SPEED_T * sin_t[mrot];
        ny = my - SPEED_T * sin_t[(mrot + 4) % 16];
        if (mcoll) begin hexp = 1'b1; m_st = EXPL_EN ? 2 : 0; mexpl = 0; end
        else if (nx < 0 || nx > 4095 || ny < 0 || ny > 4095 || ny / 16 >= 240) m_st = 0;
        else if (mlife + 1 == LIFE_T) m_st = 0;
        else begin mx = nx; my = ny; mlife++; end
      end
      default: if (mexpl + 1 == EXPL_T) m_st = 0; else mexpl++;
    endcase
    mcoll = 1'b0;
  endtask

  task automatic tick();
    bit hexp;
    @(negedge clk); vsync = 1'b1;
    @(negedge clk); m_tick(hexp);
    chk("tick_hit", hit, hexp);
    chk("tick_active", active, m_st != 0);
    vsync = 1'b0;
    @(negedge clk); chk("hit_width", hit, 0);
  endtask

  task automatic set_fire(bit v);
    @(negedge clk); fire = v;
    @(negedge clk);
    if (v && !mfire_prev && m_st == 0) mreq = 1'b1;
    mfire_prev = v;
  endtask

  task automatic probe_exp(string nm, int h, int v, bit exp);
    @(negedge clk); hpos = 9'(h); vpos = 9'(v);
    @(negedge clk); chk(nm, gfx, exp);
  endtask

  task automatic probe(string nm, int h, int v);
    probe_exp(nm, h, v, m_gfx(h, v));
  endtask

  task automatic collide(int h, int v);
    @(negedge clk); hpos = 9'(h); vpos = 9'(v); playfield = 1'b1;
    repeat (3) @(negedge clk);
    if (m_st == 1 && m_gfx(h, v)) mcoll = 1'b1;
    playfield = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b0; m_reset();
    @(negedge clk);
    chk("rst_active", active, 0); chk("rst_gfx", gfx, 0); chk("rst_hit", hit, 0);
    reset = 1'b1;
    mfire_prev = fire;
    if (fire) mreq = 1'b1;
  endtask

  task automatic launch(int tx, int ty, int r);
    tank_x = 8'(tx); tank_y = 8'(ty); tank_rot = 4'(r);
    set_fire(1'b1); set_fire(1'b0);
    tick();
  endtask

  initial begin
    tbl[0]  = '{100, 100, 0,  16, 1'b1, 108, 101};
    tbl[1]  = '{100, 100, 4,  16, 1'b1, 115, 108};
    tbl[2]  = '{100, 100, 4,  59, 1'b1, 133, 108};
    tbl[3]  = '{100, 100, 4,  60, 1'b0, 0,   0};
    tbl[4]  = '{240, 50,  4,  18, 1'b1, 255, 58};
    tbl[5]  = '{240, 50,  4,  19, 1'b0, 0,   0};
    tbl[6]  = '{10,  0,   0,  18, 1'b1, 18,  0};
    tbl[7]  = '{10,  0,   0,  19, 1'b0, 0,   0};
    tbl[8]  = '{0,   20,  12, 18, 1'b1, 0,   28};
    tbl[9]  = '{50,  60,  2,  10, 1'b1, 61,  66};
    tbl[10] = '{0,   225, 8,  15, 1'b1, 8,   239};
    tbl[11] = '{0,   225, 8,  16, 1'b0, 0,   0};

    foreach (tbl[i]) begin
      do_reset();
      launch(tbl[i].tx, tbl[i].ty, tbl[i].rot);
      chk("tv_launch", active, 1);
      repeat (tbl[i].n) tick();
      chk("tv_active", active, int'(tbl[i].act));
      if (tbl[i].act) begin
        probe_exp("tv_pix",    tbl[i].xi,     tbl[i].yi,     1'b1);
        probe_exp("tv_pix_br", tbl[i].xi + 1, tbl[i].yi + 1, 1'b1);
        probe_exp("tv_right",  tbl[i].xi + 2, tbl[i].yi,     1'b0);
        probe_exp("tv_below",  tbl[i].xi,     tbl[i].yi + 2, 1'b0);
        probe_exp("tv_left",   tbl[i].xi - 1, tbl[i].yi,     1'b0);
      end
    end

    // Collision ends flight with a single-clock hit.
    do_reset();
    launch(100, 100, 4);
    repeat (3) tick();
    probe_exp("coll_pix", 109, 108, 1'b1);
    collide(109, 108);
    tick();
    chk("coll_hit_model", int'(EXPL_EN) + 1, m_st + 1);
`ifdef MISSILE_EXPLODE_EN
    for (int k = 0; k < EXPL_T; k++) begin
      probe("expl_px", 109, 108);
      tick();
    end
    chk("expl_done", active, 0);
`else
    chk("coll_idle", active, 0);
`endif

    // Fire edge in flight is ignored; held fire does not relaunch.
    do_reset();
    launch(100, 100, 4);
    repeat (2) tick();
    tank_x = 8'd20; tank_y = 8'd20;
    set_fire(1'b1);
    repeat (2) tick();
    probe_exp("no_reload", 109, 108, 1'b1);
    repeat (LIFE_T) tick();
    chk("held_no_relaunch", active, 0);
    set_fire(1'b0); set_fire(1'b1); set_fire(1'b0);
    tick();
    chk("relaunch", active, 1);
    probe_exp("relaunch_pix", 28, 28, 1'b1);

    // Asynchronous reset in flight.
    do_reset();
    launch(100, 100, 4);
    repeat (2) tick();
    probe_exp("pre_rst_pix", 109, 108, 1'b1);
    @(posedge clk); #2 reset = 1'b0; m_reset();
    #1;
    chk("async_active", active, 0);
    chk("async_gfx", gfx, 0);
    chk("async_hit", hit, 0);
    @(negedge clk); reset = 1'b1;
    launch(30, 40, 0);
    chk("post_rst_launch", active, 1);
    probe_exp("post_rst_pix", 38, 48, 1'b1);

    // Random play against the model.
    do_reset();
    for (int it = 0; it < 500; it++) begin
      case ($urandom_range(0, 11))
        0, 1, 2, 3, 4: tick();
        5: set_fire(!fire);
        6, 7: if (m_st != 0) probe("rnd_px", mx / 16 + int'($urandom_range(0, 5)) - 2,
                                   my / 16 + int'($urandom_range(0, 5)) - 2);
              else probe("rnd_idle", int'($urandom_range(0, 511)), int'($urandom_range(0, 511)));
        8: begin tank_x = 8'($urandom); tank_y = 8'($urandom); tank_rot = 4'($urandom); end
        9, 10: collide(mx / 16 + int'($urandom_range(0, 2)) - 1, my / 16 + int'($urandom_range(0, 1)));
        default: if ($urandom_range(0, 9) == 0) do_reset();
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
